fetch_stage: RTL

- IF stage of the pipelined ARM core. It owns the PC, issues fetches to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register that feeds decode.
- Consumes the hazard unit's stall and the EX-stage condition handler's taken-branch redirect.
- Produces instruction, PC+4 and valid for ID.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_hold_buf.sv | 56 +++++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage.
// The hazard unit also uses these definitions, for bubble detection.
//   fetch_state_e  : fetch FSM state encoding
//   NopWord        : bubble instruction placed in IF/ID (andeq r0,r0,r0)
//   ResetPcDefault : default PC loaded on reset
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StHold   = 2'd1,
    StSquash = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NopWord        = 32'h0000_0000;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

  // Branch targets are always word aligned; the low bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory req/ack bus between the fetch stage and instruction RAM.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : word-aligned fetch byte address (master -> slave)
//   imem_ack   : one-cycle pulse, imem_rdata valid (slave -> master)
//   imem_rdata : fetched instruction word (slave -> master)
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {inst, pc4} buffer. It parks a word that arrived while decode was stalled.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   load_i           : capture inst_i/pc4_i and set full
//   clear_i          : empty the buffer (load wins if both are set)
//   inst_i, pc4_i    : word to capture
//   inst_o, pc4_o    : buffered word
//   full_o           : buffer holds a word
module fetch_hold_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc4_o,
  output logic        full_o
);
  import fetch_stage_pkg::*;

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        full_q, full_d;

  always_comb begin
    inst_d = inst_q;
    pc4_d  = pc4_q;
    full_d = full_q;
    if (load_i) begin
      inst_d = inst_i;
      pc4_d  = pc4_i;
      full_d = 1'b1;
    end else if (clear_i) begin
      inst_d = NopWord;
      pc4_d  = 32'h0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_q <= NopWord;
      pc4_q  <= 32'h0;
      full_q <= 1'b0;
    end else begin
      inst_q <= inst_d;
      pc4_q  <= pc4_d;
      full_q <= full_d;
    end
  end

  assign inst_o = inst_q;
  assign pc4_o  = pc4_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage. It owns the PC, fetches over the imem req/ack bus and loads the IF/ID register.
//   CLK, CLR    : clock, asynchronous active-high reset
//   stall       : hazard unit, hold PC and IF/ID
//   br_taken    : taken-branch redirect from EX
//   br_target   : redirect address (low two bits ignored)
//   imem        : instruction memory bus (master side)
//   pc          : current fetch PC
//   ifid_inst   : IF/ID instruction
//   ifid_pc4    : IF/ID PC+4
//   ifid_valid  : IF/ID holds a real instruction
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault,
  parameter logic [31:0] NOP_WORD = NopWord
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          pc,
  output logic [31:0]          ifid_inst,
  output logic [31:0]          ifid_pc4,
  output logic                 ifid_valid
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         req_q;
  logic [31:0]  redirect_q;
  logic [31:0]  ifid_inst_q;
  logic [31:0]  ifid_pc4_q;
  logic         ifid_valid_q;

  logic [31:0]  tgt;
  logic [31:0]  pc_plus4;
  logic         ack_v;
  logic         hb_load;
  logic         hb_clear;
  logic [31:0]  hb_inst;
  logic [31:0]  hb_pc4;
  logic         hb_full;

  assign tgt      = align_word(br_target);
  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32
  // An ack only counts against a request that is actually on the bus; this also
  // swallows a stale ack in the first cycle after reset.
  assign ack_v    = imem.imem_ack & req_q;

  assign hb_load  = (state_q == StFetch) && ack_v && stall && !br_taken;
  assign hb_clear = (state_q == StHold) && (br_taken || !stall);

  fetch_hold_buf u_hold_buf (
    .clk_i   (CLK),
    .rst_i   (CLR),
    .load_i  (hb_load),
    .clear_i (hb_clear),
    .inst_i  (imem.imem_rdata),
    .pc4_i   (pc_plus4),
    .inst_o  (hb_inst),
    .pc4_o   (hb_pc4),
    .full_o  (hb_full)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      redirect_q   <= RESET_PC;
      ifid_inst_q  <= NOP_WORD;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          req_q <= 1'b1;
          if (br_taken) begin
            ifid_inst_q  <= NOP_WORD;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            if (ack_v) begin
              pc_q <= tgt;
            end else begin
              // Old request is still in flight; keep it stable and drop its data.
              redirect_q <= tgt;
              state_q    <= StSquash;
            end
          end else if (stall) begin
            if (ack_v) begin
              pc_q    <= pc_plus4;
              state_q <= StHold;
              req_q   <= 1'b0;
            end
          end else if (ack_v) begin
            ifid_inst_q  <= imem.imem_rdata;
            ifid_pc4_q   <= pc_plus4;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_plus4;
          end else begin
            ifid_inst_q  <= NOP_WORD;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
          end
        end

        StHold: begin
          if (br_taken) begin
            ifid_inst_q  <= NOP_WORD;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            pc_q         <= tgt;
            state_q      <= StFetch;
            req_q        <= 1'b1;
          end else if (!stall) begin
            ifid_inst_q  <= hb_inst;
            ifid_pc4_q   <= hb_pc4;
            ifid_valid_q <= hb_full;
            state_q      <= StFetch;
            req_q        <= 1'b1;
          end
        end

        StSquash: begin
          if (br_taken) begin
            redirect_q <= tgt;
          end
          if (ack_v) begin
            // Latest redirect wins, including one arriving with the ack.
            pc_q    <= br_taken ? tgt : redirect_q;
            state_q <= StFetch;
          end
        end

        default: begin
          state_q <= StFetch;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign ifid_inst      = ifid_inst_q;
  assign ifid_pc4       = ifid_pc4_q;
  assign ifid_valid     = ifid_valid_q;

endmodule
